// File: rtl/pn_event_display.sv
// pn_event_display: queues Petri-net firing events and replays them on the
// active-low LEDs with a dwell/gap cadence; also flags a stalled net.
module pn_event_display #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DWELL_CYCLES    = 13_500_000,
  parameter int unsigned GAP_CYCLES      = 2_700_000,
  parameter int unsigned DEADLOCK_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        fire_valid,
  input  logic [1:0]  fire_id,
  input  logic [31:0] fire_count,
  output logic [5:0]  led,
  output logic        deadlock,
  output logic [7:0]  drop_count,
  output logic [15:0] fire_total
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = 32;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] cnt;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  entry_t          disp_q, disp_d;
  logic [5:0]      led_q, led_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  entry_t          mem_q [DEPTH];
  logic [TW-1:0]   idle_q, idle_d;
  logic            deadlock_q, deadlock_d;
  logic [7:0]      drop_q, drop_d;
  logic [15:0]     total_q, total_d;

  logic            event_c;
  logic            empty_c;
  logic            full_c;
  logic            pop_c;
  logic            push_c;
  entry_t          entry_in_c;

  // Event qualification, FIFO status and accept decision
  always_comb begin
    event_c       = fire_valid && (fire_id != 2'd0);
    empty_c       = (wr_ptr_q == rd_ptr_q);
    full_c        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_c         = (state_q == IDLE) && !empty_c;
    push_c        = event_c && (!full_c || pop_c);
    entry_in_c.id  = fire_id;
    entry_in_c.cnt = (fire_count > 32'd15) ? 4'hF : fire_count[3:0];
    wr_ptr_d      = wr_ptr_q + PW'(push_c);
    rd_ptr_d      = rd_ptr_q + PW'(pop_c);
  end

  // Display FSM next state, shared dwell/gap timer and LED image
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          disp_d  = mem_q[rd_ptr_q[AW-1:0]];
          tmr_d   = TW'(DWELL_CYCLES);
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (tmr_q == TW'(1)) begin
          tmr_d   = TW'(GAP_CYCLES);
          state_d = GAP;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      GAP: begin
        if (tmr_q == TW'(1)) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    led_d = (state_d == SHOW) ? ~{disp_d.id, disp_d.cnt} : 6'h3F;
  end

  // Statistics counters and idle/deadlock tracking
  always_comb begin
    total_d = total_q + 16'(push_c);
    drop_d  = drop_q;
    if (event_c && !push_c && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    if (event_c) begin
      idle_d = '0;
    end else if (idle_q == TW'(DEADLOCK_CYCLES)) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + TW'(1);
    end
    deadlock_d = (idle_d == TW'(DEADLOCK_CYCLES));
  end

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge sys_clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry_in_c;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      disp_q     <= '0;
      led_q      <= 6'h3F;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idle_q     <= '0;
      deadlock_q <= 1'b0;
      drop_q     <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      disp_q     <= disp_d;
      led_q      <= led_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idle_q     <= idle_d;
      deadlock_q <= deadlock_d;
      drop_q     <= drop_d;
      total_q    <= total_d;
    end
  end

  assign led        = led_q;
  assign deadlock   = deadlock_q;
  assign drop_count = drop_q;
  assign fire_total = total_q;

endmodule
